// File: rtl/drm_sdpram_34x256_pkg.sv
// Shared widths and word type for the 256 x 34 simple dual-port RAM.
package drm_sdpram_34x256_pkg;

  localparam int DRM_ADDR_WIDTH = 8;
  localparam int DRM_DATA_WIDTH = 34;
  localparam int DRM_DEPTH      = 1 << DRM_ADDR_WIDTH;

  typedef logic [DRM_DATA_WIDTH-1:0] drm_word_t;
  typedef logic [DRM_ADDR_WIDTH-1:0] drm_addr_t;

  // Clocks from the rd_addr sample edge to valid rd_data.
  function automatic int drm_read_latency(input int output_reg);
    return (output_reg != 0) ? 2 : 1;
  endfunction

endpackage

// File: rtl/drm_sdpram_34x256_if.sv
// Write/read port bundle of the simple dual-port RAM.
import drm_sdpram_34x256_pkg::*;

interface drm_sdpram_34x256_if #(
    parameter int ADDR_WIDTH = DRM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DRM_DATA_WIDTH
);

    // No valid/ready: wr_en qualifies the write port on each rising edge; the
    // read port has no enable, rd_addr is sampled every edge and rd_data
    // returns that word after the build's fixed latency.
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  rd_addr,
        output rd_data
    );

endinterface

// File: rtl/drm_sdpram_core.sv
// Memory array with a single write port and a registered, read-first read port.
import drm_sdpram_34x256_pkg::*;

module drm_sdpram_core #(
    parameter int ADDR_WIDTH = DRM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DRM_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Zero initial contents model the simulation power-up state; reset never clears them.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    logic [DATA_WIDTH-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (wr_en && rst_n) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Sampling mem before the same-edge write lands gives read-first behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/drm_sdpram_34x256.sv
// 256 x 34 simple dual-port RAM top: core plus optional output pipeline register.
import drm_sdpram_34x256_pkg::*;

module drm_sdpram_34x256 #(
    parameter int ADDR_WIDTH = DRM_ADDR_WIDTH,
    parameter int DATA_WIDTH = DRM_DATA_WIDTH,
    parameter int OUTPUT_REG = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    drm_sdpram_34x256_if.slave     bus
);

    logic [DATA_WIDTH-1:0] core_rd_data;

    drm_sdpram_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (bus.rd_addr),
        .rd_data (core_rd_data)
    );

    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] out_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_q <= '0;
                end else begin
                    out_q <= core_rd_data;
                end
            end

            assign bus.rd_data = out_q;
        end else begin : g_no_out_reg
            assign bus.rd_data = core_rd_data;
        end
    endgenerate

endmodule

// File: tb/tb_drm_sdpram_34x256.sv
// Randomized and directed checks of drm_sdpram_34x256 against an array/queue reference model.
import drm_sdpram_34x256_pkg::*;

module tb_drm_sdpram_34x256;

  localparam int OUTPUT_REG = 0;
  localparam int LAT        = (OUTPUT_REG != 0) ? 2 : 1;
  localparam int DW         = DRM_DATA_WIDTH;
  localparam int AW         = DRM_ADDR_WIDTH;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  drm_sdpram_34x256_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  drm_sdpram_34x256 #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .OUTPUT_REG (OUTPUT_REG)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model / scoreboard ----------------
  drm_word_t  ref_mem [DRM_DEPTH];
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic reset_model();
    exp_q.delete();
    for (int i = 0; i < LAT; i++) exp_q.push_back('0);
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%09h expected 0x%09h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  // ---------------- driver ----------------
  // Drive one clock of stimulus, advance the model at the edge, then check rd_data.
  task automatic cycle(input string tag, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [AW-1:0] ra);
    logic [DW-1:0] rd_val;
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.rd_addr = ra;
    @(posedge clk);
    if (!rst_n) begin
      reset_model();
    end else begin
      rd_val = ref_mem[ra];
      if (we) ref_mem[wa] = wd;
      exp_q.push_back(rd_val);
      void'(exp_q.pop_front());
    end
    #1;
    check(tag, bus.rd_data, exp_q[0]);
  endtask

  task automatic idle_read(input string tag, input logic [AW-1:0] ra);
    cycle(tag, 1'b0, AW'($urandom_range(255, 0)), rand_word(), ra);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < DRM_DEPTH; i++) ref_mem[i] = '0;
    reset_model();
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_addr = '0;

    // Reset held 20 cycles, rd_addr toggling, writes to addr 7 attempted and ignored.
    for (int i = 0; i < 20; i++) begin
      cycle("reset_hold", 1'b1, 8'd7, rand_word(), (i % 2 == 0) ? 8'h00 : 8'hFF);
      check("reset_zero", bus.rd_data, '0);
    end
    #2 rst_n = 1'b1;

    // First read of an unwritten address returns the simulation init value.
    for (int i = 0; i < LAT + 1; i++) idle_read("unwritten_7", 8'd7);
    check("unwritten_7_zero", bus.rd_data, '0);

    // Full fill with data = 0x3_FFFF_FFFF - addr, then back-to-back readback.
    for (int a = 0; a < DRM_DEPTH; a++)
      cycle("fill", 1'b1, AW'(a), 34'h3_FFFF_FFFF - DW'(a), AW'($urandom_range(255, 0)));
    for (int a = 0; a < DRM_DEPTH; a++) idle_read("fill_readback", AW'(a));
    for (int i = 0; i < LAT; i++) idle_read("fill_flush", 8'd0);

    // Read-during-write on addr 5 is read-first.
    cycle("rdw_setup", 1'b1, 8'd5, 34'h1_2345_6789, 8'd0);
    cycle("rdw_same", 1'b1, 8'd5, 34'h2_AAAA_5555, 8'd5);
    for (int i = 0; i < LAT - 1; i++) idle_read("rdw_wait", 8'd5);
    check("rdw_old_word", bus.rd_data, 34'h1_2345_6789);
    idle_read("rdw_next", 8'd5);
    check("rdw_new_word", bus.rd_data, 34'h2_AAAA_5555);

    // wr_en=0 with varying address/data leaves memory untouched.
    for (int i = 0; i < 50; i++)
      cycle("wr_en_low", 1'b0, AW'($urandom_range(255, 0)), rand_word(), AW'($urandom_range(255, 0)));
    for (int a = 0; a < DRM_DEPTH; a++) idle_read("wr_en_low_readback", AW'(a));
    for (int i = 0; i < LAT; i++) idle_read("wr_en_low_flush", 8'd0);

    // Mid-stream 1-cycle reset pulse during a read burst.
    for (int a = 0; a < 8; a++) idle_read("burst_pre", AW'(a));
    #2 rst_n = 1'b0;
    reset_model();
    #1 check("midrst_async_zero", bus.rd_data, '0);
    idle_read("midrst_low", 8'd9);
    check("midrst_low_zero", bus.rd_data, '0);
    #2 rst_n = 1'b1;
    idle_read("burst_post_10", 8'd10);
    idle_read("burst_post_11", 8'd11);
    for (int i = 0; i < LAT - 1; i++) idle_read("burst_post_wait", 8'd12);
    if (LAT == 1) begin
      check("midrst_addr11", bus.rd_data, 34'h3_FFFF_FFF4);
    end else begin
      check("midrst_addr10", bus.rd_data, 34'h3_FFFF_FFF5);
      idle_read("burst_post_12", 8'd12);
      check("midrst_addr11", bus.rd_data, 34'h3_FFFF_FFF4);
    end

    // Random mixed traffic, including same-address collisions.
    for (int i = 0; i < 600; i++) begin
      logic [AW-1:0] wa;
      logic [AW-1:0] ra;
      wa = AW'($urandom_range(255, 0));
      ra = ($urandom_range(3, 0) == 0) ? wa : AW'($urandom_range(255, 0));
      cycle("random", ($urandom_range(1, 0) == 1), wa, rand_word(), ra);
    end

    // Final sweep 255 down through 0 and wrap to 255 again.
    for (int a = DRM_DEPTH - 1; a >= 0; a--) idle_read("final_sweep", AW'(a));
    idle_read("final_wrap", 8'hFF);
    for (int i = 0; i < LAT; i++) idle_read("final_flush", 8'd0);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/drm_sdpram_34x256.md
Name: drm_sdpram_34x256

Overview:
- Simple dual-port block RAM: 256 words x 34 bits, one write port and one read port.
- Both ports run on a single clock.
- The read port is synchronous: the address is registered and data appears after a fixed latency.
- Used as generic storage in the FPGA shell (buffers, tag/data arrays); wraps a device BRAM primitive or infers one.

Parameters:
- ADDR_WIDTH, 8: word address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 34: word width, same for the write and read ports.
- OUTPUT_REG, 0: 1 adds a pipeline register on rd_data (latency 2 instead of 1).

Ports:
- clk  in  1  clock for both ports; all sampling on the rising edge.
- rst_n  in  1  asynchronous active-low reset; clears read-path registers only.
- wr_en  in  1  write enable.
- wr_addr  in  ADDR_WIDTH  write word address.
- wr_data  in  DATA_WIDTH  write data.
- rd_addr  in  ADDR_WIDTH  read word address; sampled every cycle, there is no read enable.
- rd_data  out  DATA_WIDTH  read data.

Behaviour:
- Write: on a rising clk edge with wr_en=1 and rst_n=1, mem[wr_addr] <= wr_data. With wr_en=0, memory is unchanged.
- Read, OUTPUT_REG=0: rd_data in cycle n+1 equals mem[rd_addr sampled at edge n]. Latency 1 clock.
- Read, OUTPUT_REG=1: a second register stage is added, so latency is 2 clocks.
- The read is always active; rd_data follows rd_addr every cycle.
- Reset:
  - rst_n=0 asynchronously forces rd_data and every read pipeline register to 0.
  - Writes are ignored while rst_n=0.
  - Memory contents are NOT cleared by reset.
  - On release, the first valid rd_data appears one latency after the first post-reset edge.
- Power-up: memory content is undefined. Simulation models initialise every word to 0.
- Read-during-write to the same address in the same cycle is read-first: rd_data returns the old word, and the new word is visible on the next read.
- Writes and reads to different addresses in the same cycle are fully independent.
- Address range:
  - Addresses cover the full range 0..255 with no out-of-range case.
  - Address 255 followed by address 0 needs no special handling.
- Width rules: wr_data is stored unmodified at all 34 bits; there is no byte enable and no parity.
- Reset asserted mid-stream: rd_data goes to 0 immediately, and previously written data remains readable after release.

Decomposition:
- Shared package: DRM_ADDR_WIDTH=8, DRM_DATA_WIDTH=34 and a typedef for the 34-bit data word.
- One natural sub-module, drm_sdpram_core:
  - memory array, write logic and the registered read;
  - the top adds the optional OUTPUT_REG stage and the reset handling of the output path.

Test Plan:
- Reset: hold rst_n=0 for 20 cycles with rd_addr toggling -> rd_data stays 0x0_0000_0000. After release, the first read of an unwritten address returns 0 (simulation init).
- Full fill/readback:
  - Stimulus: write addresses 0..255 with data = 0x3_FFFF_FFFF - addr, then read addresses 0..255 back-to-back, one per cycle.
  - Required: each rd_data matches one cycle after its address (OUTPUT_REG=0), e.g. addr 0 -> 0x3_FFFF_FFFF, addr 255 -> 0x3_FFFF_FF00; zero mismatches.
- Read-during-write:
  - Stimulus: mem[5]=0x1_2345_6789; in the same cycle write 0x2_AAAA_5555 to addr 5 and read addr 5.
  - Required: rd_data=0x1_2345_6789; the next read returns 0x2_AAAA_5555.
- wr_en=0 with varying wr_addr/wr_data for 50 cycles -> readback of all addresses unchanged.
- Mid-stream reset:
  - Stimulus: pulse rst_n low for 1 cycle during a read burst.
  - Required: rd_data=0 while low; after release, reads of addrs 10,11 return previously written 0x3_FFFF_FFF5, 0x3_FFFF_FFF4.
- OUTPUT_REG=1 build: repeat the fill/readback -> data appears exactly 2 cycles after its address, zero mismatches.
